rice_encoder_pipe: RTL

Parametrised, back-pressurable Rice residual encoder, the next generation of the encoder stage. It sits between the LPC residual generator and the bitstream packer. It zig-zag maps signed residuals, splits them by a per-sample Rice parameter, and applies an escape code for oversized quotients. Each code is emitted with its total bit length, and bits are accumulated per partition so the controller can compare partition costs.

---
 rtl/rice_pkg.sv | 29 ++
 rtl/rice_part_accum.sv | 44 ++++
 rtl/rice_encoder_pipe.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/rice_pkg.sv
// Shared helpers for the Rice residual encoder: zig-zag map, parameter
// clamp and code-length formula. Functions work on wide operands so the
// callers can stay parametrised on their own sample width.
package rice_pkg;

  localparam int FN_W = 64;

  // Signed-to-unsigned zig-zag: 0,-1,1,-2,2 ... -> 0,1,2,3,4 ...
  // The result is masked back to w bits so the full signed range maps exactly.
  function automatic logic [FN_W-1:0] zigzag(input logic [FN_W-1:0] s, input int w);
    logic [FN_W-1:0] mask;
    logic [FN_W-1:0] sign_fill;
    mask      = (FN_W'(1) << w) - FN_W'(1);
    sign_fill = s[w-1] ? '1 : '0;
    return ((s << 1) ^ sign_fill) & mask;
  endfunction

  // A remainder wider than the sample makes no sense; cap k at w-1.
  function automatic int clamp_k(input int k, input int w);
    return (k > w - 1) ? (w - 1) : k;
  endfunction

  // Escape codes are ESC_LIMIT zeros plus w raw bits with no terminating 1.
  function automatic int code_len(input int q, input int k, input logic esc,
                                  input int esc_limit, input int w);
    return esc ? (esc_limit + w) : (q + 1 + k);
  endfunction

endpackage

// File: rtl/rice_part_accum.sv
// Per-partition bit counter: sums code lengths of transferred beats and
// publishes the total when the beat flagged last leaves the encoder.
module rice_part_accum #(
  parameter int LW    = 6,
  parameter int ACC_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fire,
  input  logic [LW-1:0]    len,
  input  logic             last,
  output logic [ACC_W-1:0] part_bits,
  output logic             part_valid
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;

  // Running total including the beat currently transferring.
  always_comb begin
    sum = acc + ACC_W'(len);
  end

  // Accumulate, and on the partition's last beat publish and restart from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc        <= '0;
      part_bits  <= '0;
      part_valid <= 1'b0;
    end else begin
      part_valid <= 1'b0;
      if (fire) begin
        if (last) begin
          part_bits  <= sum;
          part_valid <= 1'b1;
          acc        <= '0;
        end else begin
          acc <= sum;
        end
      end
    end
  end

endmodule

// File: rtl/rice_encoder_pipe.sv
// Three-stage back-pressurable Rice encoder: S0 registers the residual,
// S1 zig-zag maps it, S2 splits by k (or escapes) and drives the output.
// Every stage advances when empty or when the stage after it drains, so
// bubbles collapse and a full pipe stalls only when the output stalls.
module rice_encoder_pipe
  import rice_pkg::*;
#(
  parameter  int SAMPLE_W  = 16,
  parameter  int PARAM_W   = 4,
  parameter  int ESC_LIMIT = 32,
  parameter  int ACC_W     = 24,
  localparam int QW        = $clog2(ESC_LIMIT + 1),
  localparam int LW        = $clog2(ESC_LIMIT + SAMPLE_W + 1)
) (
  input  logic                       iClock,
  input  logic                       iReset,
  input  logic                       iValid,
  output logic                       oReady,
  input  logic signed [SAMPLE_W-1:0] iSample,
  input  logic        [PARAM_W-1:0]  iRiceParam,
  input  logic                       iLast,
  output logic                       oValid,
  input  logic                       iReady,
  output logic        [QW-1:0]       oMSB,
  output logic        [SAMPLE_W-1:0] oLSB,
  output logic                       oEscape,
  output logic        [LW-1:0]       oCodeLen,
  output logic                       oLast,
  output logic        [ACC_W-1:0]    oPartBits,
  output logic                       oPartValid
);

  logic                       v0, v1;
  logic signed [SAMPLE_W-1:0] s0;
  logic        [PARAM_W-1:0]  k0, k1;
  logic                       last0, last1;
  logic        [SAMPLE_W-1:0] u1;

  logic ld1, ld2, mv0, mv1, xfer;

  logic [FN_W-1:0]     zz;
  logic [SAMPLE_W-1:0] q_c, marker_c, lsb_c;
  logic                esc_c;
  logic [QW-1:0]       msb_c;
  logic [LW-1:0]       len_c;

  // Handshake chain: a stage loads when empty or when its successor moves.
  always_comb begin
    ld2    = !oValid || iReady;
    mv1    = v1 && ld2;
    ld1    = !v1 || mv1;
    mv0    = v0 && ld1;
    oReady = !v0 || mv0;
    xfer   = oValid && iReady;
  end

  // Stage 0: capture the residual, its last flag and the clamped parameter.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      v0    <= 1'b0;
      s0    <= '0;
      k0    <= '0;
      last0 <= 1'b0;
    end else if (oReady) begin
      v0 <= iValid;
      if (iValid) begin
        s0    <= iSample;
        k0    <= PARAM_W'(clamp_k(int'(iRiceParam), SAMPLE_W));
        last0 <= iLast;
      end
    end
  end

  // Zig-zag map of the stage-0 residual.
  always_comb begin
    zz = zigzag(FN_W'(s0), SAMPLE_W);
  end

  // Stage 1: hold the unsigned mapped value.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      v1    <= 1'b0;
      u1    <= '0;
      k1    <= '0;
      last1 <= 1'b0;
    end else if (ld1) begin
      v1 <= v0;
      if (v0) begin
        u1    <= zz[SAMPLE_W-1:0];
        k1    <= k0;
        last1 <= last0;
      end
    end
  end

  // Quotient/remainder split with escape for oversized quotients.
  always_comb begin
    q_c      = u1 >> k1;
    esc_c    = (32'(q_c) >= 32'(ESC_LIMIT));
    marker_c = SAMPLE_W'(1) << k1;
    lsb_c    = esc_c ? u1 : (marker_c | (u1 & (marker_c - SAMPLE_W'(1))));
    msb_c    = esc_c ? QW'(ESC_LIMIT) : QW'(q_c);
    len_c    = LW'(code_len(32'(q_c), 32'(k1), esc_c, ESC_LIMIT, SAMPLE_W));
  end

  // Stage 2: output register, frozen while the packer stalls.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      oValid   <= 1'b0;
      oMSB     <= '0;
      oLSB     <= '0;
      oEscape  <= 1'b0;
      oCodeLen <= '0;
      oLast    <= 1'b0;
    end else if (ld2) begin
      oValid <= v1;
      if (v1) begin
        oMSB     <= msb_c;
        oLSB     <= lsb_c;
        oEscape  <= esc_c;
        oCodeLen <= len_c;
        oLast    <= last1;
      end
    end
  end

  rice_part_accum #(
    .LW    (LW),
    .ACC_W (ACC_W)
  ) u_part_accum (
    .clk        (iClock),
    .rst        (iReset),
    .fire       (xfer),
    .len        (oCodeLen),
    .last       (oLast),
    .part_bits  (oPartBits),
    .part_valid (oPartValid)
  );

endmodule
